// File: rtl/operand_fetch.sv
// Operand fetch stage: selects two operands from the register file with
// same-cycle write-back forwarding and holds them in a single valid/ready slot.
module operand_fetch #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic [WIDTH-1:0] r4,
  input  logic [WIDTH-1:0] r5,
  input  logic [WIDTH-1:0] r6,
  input  logic [WIDTH-1:0] r7,
  input  logic [WIDTH-1:0] r8,
  input  logic [WIDTH-1:0] r9,
  input  logic [WIDTH-1:0] r10,
  input  logic [WIDTH-1:0] r11,
  input  logic [WIDTH-1:0] r12,
  input  logic [WIDTH-1:0] r13,
  input  logic [WIDTH-1:0] r14,
  input  logic [WIDTH-1:0] r15,
  input  logic [WIDTH-1:0] wb_bus,
  input  logic [15:0]      wb_enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       src_a,
  input  logic [3:0]       src_b,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [3:0]       out_dst
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } stage_t;

  stage_t state, state_nxt;

  logic [WIDTH-1:0] regs [16];
  logic [WIDTH-1:0] fetch_a, fetch_b;
  logic [3:0]       held_src_a, held_src_b;
  logic             held_use_imm;
  logic             accept, stall;

  always_comb begin
    regs[0]  = r0;  regs[1]  = r1;  regs[2]  = r2;  regs[3]  = r3;
    regs[4]  = r4;  regs[5]  = r5;  regs[6]  = r6;  regs[7]  = r7;
    regs[8]  = r8;  regs[9]  = r9;  regs[10] = r10; regs[11] = r11;
    regs[12] = r12; regs[13] = r13; regs[14] = r14; regs[15] = r15;
  end

  assign out_valid = (state == S_FULL);
  assign in_ready  = !reset && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign stall     = out_valid && !out_ready;

  // Forwarding looks only at the enable bit of the selected register.
  always_comb begin
    fetch_a = wb_enable[src_a] ? wb_bus : regs[src_a];
    fetch_b = use_imm ? imm : (wb_enable[src_b] ? wb_bus : regs[src_b]);
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = S_FULL;
    else if (out_valid && out_ready)
      state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a         <= '0;
      op_b         <= '0;
      out_dst      <= '0;
      held_src_a   <= '0;
      held_src_b   <= '0;
      held_use_imm <= 1'b0;
    end else if (accept) begin
      op_a         <= fetch_a;
      op_b         <= fetch_b;
      out_dst      <= dst;
      held_src_a   <= src_a;
      held_src_b   <= src_b;
      held_use_imm <= use_imm;
    end else if (stall) begin
      // A write to a source register while stalled replaces the held value.
      if (wb_enable[held_src_a])
        op_a <= wb_bus;
      if (!held_use_imm && wb_enable[held_src_b])
        op_b <= wb_bus;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch: each record gives one cycle
// of inputs plus the expected in_ready before the edge and outputs after it.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rf [16];
  logic [15:0] wb_bus, wb_enable, imm;
  logic        in_valid, in_ready, use_imm, out_valid, out_ready;
  logic [3:0]  src_a, src_b, dst, out_dst;
  logic [15:0] op_a, op_b;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  operand_fetch #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .r0(rf[0]), .r1(rf[1]), .r2(rf[2]), .r3(rf[3]),
    .r4(rf[4]), .r5(rf[5]), .r6(rf[6]), .r7(rf[7]),
    .r8(rf[8]), .r9(rf[9]), .r10(rf[10]), .r11(rf[11]),
    .r12(rf[12]), .r13(rf[13]), .r14(rf[14]), .r15(rf[15]),
    .wb_bus(wb_bus), .wb_enable(wb_enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .use_imm(use_imm), .imm(imm), .dst(dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .out_dst(out_dst)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic        ui;
    logic [15:0] imm;
    logic [3:0]  dst;
    logic        ordy;
    logic [15:0] wbe;
    logic [15:0] wbb;
    logic        eir;
    logic        ev;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [3:0]  ed;
  } vec_t;

  function automatic vec_t mkv(logic rst, logic iv, logic [3:0] sa, logic [3:0] sb,
                               logic ui, logic [15:0] im, logic [3:0] d, logic ordy,
                               logic [15:0] wbe, logic [15:0] wbb, logic eir, logic ev,
                               logic [15:0] ea, logic [15:0] eb, logic [3:0] ed);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sa = sa; v.sb = sb; v.ui = ui; v.imm = im; v.dst = d;
    v.ordy = ordy; v.wbe = wbe; v.wbb = wbb;
    v.eir = eir; v.ev = ev; v.ea = ea; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle well clear of the edge, check in_ready, clock, check outputs.
  task automatic run(input vec_t v, input string nm);
    reset = v.rst; in_valid = v.iv; src_a = v.sa; src_b = v.sb; use_imm = v.ui;
    imm = v.imm; dst = v.dst; out_ready = v.ordy; wb_enable = v.wbe; wb_bus = v.wbb;
    #1;
    chk({nm, " in_ready"}, {15'd0, in_ready}, {15'd0, v.eir});
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, {15'd0, out_valid}, {15'd0, v.ev});
    chk({nm, " op_a"}, op_a, v.ea);
    chk({nm, " op_b"}, op_b, v.eb);
    chk({nm, " out_dst"}, {12'd0, out_dst}, {12'd0, v.ed});
  endtask

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
    rf[3] = 16'h1234; rf[5] = 16'h0001; rf[7] = 16'hBEEF;
    @(posedge clk); #1;

    // Reset held for two cycles with a request pending.
    run(mkv(1, 1, 3, 7, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0), "reset1");
    run(mkv(1, 1, 3, 7, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0), "reset2");
    run(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), "post_reset");

    //            rst iv sa  sb ui imm      dst ordy wbe       wbb      eir ev ea        eb        ed
    tbl[0] = mkv(0, 1, 3,  7,  0, 16'h0,  9,  1, 16'h0000, 16'h0000, 1, 1, 16'h1234, 16'hBEEF, 9);
    tbl[1] = mkv(0, 0, 0,  0,  0, 16'h0,  0,  1, 16'h0000, 16'h0000, 1, 0, 16'h1234, 16'hBEEF, 9);
    tbl[2] = mkv(0, 1, 5,  5,  0, 16'h0,  1,  1, 16'h0020, 16'h5555, 1, 1, 16'h5555, 16'h5555, 1);
    tbl[3] = mkv(0, 1, 5,  5,  1, 16'hFF, 2,  1, 16'h0020, 16'h5555, 1, 1, 16'h5555, 16'h00FF, 2);
    tbl[4] = mkv(0, 1, 3,  7,  0, 16'h0,  3,  1, 16'h0028, 16'hCAFE, 1, 1, 16'hCAFE, 16'hBEEF, 3);
    tbl[5] = mkv(0, 1, 0,  15, 0, 16'h0,  15, 1, 16'h0001, 16'h0BAD, 1, 1, 16'h0BAD, 16'hA00F, 15);
    tbl[6] = mkv(0, 0, 0,  0,  0, 16'h0,  0,  1, 16'h0000, 16'h0000, 1, 0, 16'h0BAD, 16'hA00F, 15);
    tbl[7] = mkv(0, 0, 0,  0,  0, 16'h0,  0,  0, 16'h0001, 16'h7777, 1, 0, 16'h0BAD, 16'hA00F, 15);
    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Stall refresh of op_a then op_b, then a single consume.
    rf[2] = 16'h0010; rf[4] = 16'h0020;
    run(mkv(0, 1, 2, 4, 0, 0, 6, 0, 16'h0000, 16'h0000, 1, 1, 16'h0010, 16'h0020, 6), "stall_cap");
    run(mkv(0, 1, 7, 7, 0, 0, 8, 0, 16'h0004, 16'hAAAA, 0, 1, 16'hAAAA, 16'h0020, 6), "stall_ref_a");
    run(mkv(0, 1, 7, 7, 0, 0, 8, 0, 16'h0010, 16'hBBBB, 0, 1, 16'hAAAA, 16'hBBBB, 6), "stall_ref_b");
    run(mkv(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 16'hAAAA, 16'hBBBB, 6), "stall_consume");
    run(mkv(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 16'hAAAA, 16'hBBBB, 6), "stall_once");

    // Immediate operand must not be refreshed by a write to src_b.
    run(mkv(0, 1, 2, 4, 1, 16'h1111, 5, 0, 16'h0000, 16'h0000, 1, 1, 16'h0010, 16'h1111, 5), "imm_cap");
    run(mkv(0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0014, 16'hCCCC, 0, 1, 16'hCCCC, 16'h1111, 5), "imm_stall");
    run(mkv(0, 0, 0, 0, 0, 16'h0, 0, 1, 16'h0000, 16'h0000, 1, 0, 16'hCCCC, 16'h1111, 5), "imm_drain");

    // Back-to-back: one request per cycle with out_valid held high.
    for (int i = 0; i < 4; i++) rf[i] = 16'h0010 + 16'(i);
    for (int i = 0; i < 4; i++)
      run(mkv(0, 1, 4'(i), 4'(i), 0, 0, 4'(i), 1, 0, 0, 1, 1, 16'h0010 + 16'(i),
              16'h0010 + 16'(i), 4'(i)), $sformatf("b2b%0d", i));
    run(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0013, 16'h0013, 3), "b2b_drain");

    // Reset during a stall discards the pending operands.
    run(mkv(0, 1, 1, 2, 0, 0, 7, 0, 0, 0, 1, 1, 16'h0011, 16'h0012, 7), "rst_stall_cap");
    run(mkv(1, 1, 1, 2, 0, 0, 7, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0), "rst_stall");
    run(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0), "rst_stall_after1");
    run(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0), "rst_stall_after2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion to the register file. Takes the 16 register outputs and selects two operands by source index, with forwarding from the same-cycle write-back (wb_bus/wb_enable).
- Registers the operands into a single valid/ready output stage feeding the ALU.
- Refreshes held operands if the register they came from is written while the stage is stalled, so the ALU never consumes a stale value.

Parameters:
- WIDTH, 16, data width of registers, buses and operands. Register count is fixed at 16.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- r0..r15  input  WIDTH each  current register file contents
- wb_bus  input  WIDTH  data being written to the register file this cycle
- wb_enable  input  16  one-hot write enable being applied to the register file this cycle
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready
- src_a  input  4  operand A register index
- src_b  input  4  operand B register index
- use_imm  input  1  1 = operand B taken from imm instead of src_b
- imm  input  WIDTH  immediate value
- dst  input  4  destination index, passed through
- out_valid  output  1  operands valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- op_a  output  WIDTH  operand A
- op_b  output  WIDTH  operand B
- out_dst  output  4  registered dst

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over every other event.
- Reset values: out_valid=0, op_a=0, op_b=0, out_dst=0, and all internal held indices and flags = 0.
- in_ready = !reset && (!out_valid || out_ready). It is combinational, with no dependence on in_valid.
- Capture (in_valid && in_ready at a rising edge), latency 1 cycle:
  - op_a <= wb_enable[src_a] ? wb_bus : r[src_a].
  - op_b <= use_imm ? imm : (wb_enable[src_b] ? wb_bus : r[src_b]).
  - out_dst <= dst; out_valid <= 1.
  - Held state: src_a, src_b and use_imm are stored for the refresh logic.
- Forwarding uses only bit wb_enable[src]. Other set bits are ignored, so a multi-hot wb_enable is still well defined.
- src_a == src_b: both operands get the identical (forwarded if applicable) value.
- Drain: out_valid && out_ready && !(in_valid) -> out_valid <= 0. op_a, op_b and out_dst hold their last values.
- Back-to-back: out_valid && out_ready && in_valid -> the new capture occurs in the same edge, out_valid stays 1, and sustained throughput is 1 request per cycle.
- Stall refresh (out_valid && !out_ready):
  - if wb_enable[held_src_a], op_a <= wb_bus.
  - if !held_use_imm && wb_enable[held_src_b], op_b <= wb_bus.
  - out_dst is unchanged; out_valid stays 1.
- Idle (out_valid=0): no refresh, and op_a/op_b hold their last values.
- Reset mid-stall: the pending operands are discarded and out_valid=0 the cycle after reset is sampled. in_ready=0 while reset is high.
- Unsigned data; no arithmetic; widths pass through unchanged.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, op_a=op_b=0, in_ready=0 during reset, 1 after.
- Basic fetch: r3=0x1234, r7=0xBEEF, src_a=3, src_b=7, dst=9, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, op_a=0x1234, op_b=0xBEEF, out_dst=9. Following cycle out_valid=0.
- Forwarding and immediate:
  - r5=0x0001, wb_enable=0x0020, wb_bus=0x5555, src_a=src_b=5 -> op_a=op_b=0x5555.
  - Repeat with use_imm=1, imm=0x00FF -> op_b=0x00FF.
- Stall refresh: capture src_a=2 (r2=0x0010), src_b=4 (r4=0x0020) with out_ready=0, then write wb_enable=0x0004, wb_bus=0xAAAA -> op_a=0xAAAA, op_b=0x0020, in_ready=0. Raise out_ready -> consumed once.
- Back-to-back: in_valid=1 for 4 cycles, out_ready=1, src_a=0..3 with r0..r3=0x10,0x11,0x12,0x13 -> op_a sequence 0x10,0x11,0x12,0x13 on consecutive cycles, out_valid continuously 1.
- Reset mid-stall: out_valid=1, out_ready=0, pulse reset 1 cycle -> out_valid=0, op_a=op_b=0 next cycle, and the held request is never delivered.
